// File: rtl/blackjack_pkg.sv
// Shared types and helpers for the blackjack card source: deck geometry,
// card encoding, shuffle FSM states and the rejection-sampling mask.
package blackjack_pkg;

    localparam int DECK_SIZE = 52;
    localparam int NUM_RANKS = 13;

    typedef logic [5:0] card_idx_t;

    typedef struct packed {
        logic [3:0] rank;
        logic [1:0] suit;
    } card_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        DRAW  = 3'd2,
        SWAP  = 3'd3,
        READY = 3'd4
    } deck_state_e;

    // suit = idx / 13, rank = idx % 13 + 1, done by range compare to avoid a divider
    function automatic card_t idx_to_card(input card_idx_t idx);
        card_t c;
        if (idx >= 6'd39) begin
            c.suit = 2'd3;
            c.rank = 4'(idx - 6'd38);
        end else if (idx >= 6'd26) begin
            c.suit = 2'd2;
            c.rank = 4'(idx - 6'd25);
        end else if (idx >= 6'd13) begin
            c.suit = 2'd1;
            c.rank = 4'(idx - 6'd12);
        end else begin
            c.suit = 2'd0;
            c.rank = 4'(idx + 6'd1);
        end
        return c;
    endfunction

    // Smallest 2^k-1 covering i, so a masked random draw lands in range often.
    function automatic card_idx_t draw_mask(input card_idx_t i);
        card_idx_t m;
        if (i > 6'd31)      m = 6'd63;
        else if (i > 6'd15) m = 6'd31;
        else if (i > 6'd7)  m = 6'd15;
        else if (i > 6'd3)  m = 6'd7;
        else if (i > 6'd1)  m = 6'd3;
        else                m = 6'd1;
        return m;
    endfunction

endpackage

// File: rtl/blackjack_deck_if.sv
// Card-control handshake between the game FSM (master) and the deck (slave).
interface blackjack_deck_if;
    import blackjack_pkg::*;

    logic      shuffle_req;
    logic      card_req;
    logic      shuffle_ok;
    logic      card_valid;
    logic [3:0] card_rank;
    logic [1:0] card_suit;
    card_idx_t cards_left;
    logic      deck_empty;
    logic      card_err;

    modport master (
        output shuffle_req, card_req,
        input  shuffle_ok, card_valid, card_rank, card_suit,
               cards_left, deck_empty, card_err
    );

    modport slave (
        input  shuffle_req, card_req,
        output shuffle_ok, card_valid, card_rank, card_suit,
               cards_left, deck_empty, card_err
    );
endinterface

// File: rtl/blackjack_deck_lfsr16.sv
// Free-running 16-bit Galois LFSR; advances every cycle out of reset.
module bj_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] state
);
    logic [15:0] state_q;
    logic [15:0] state_d;

    // Right-shifting Galois step: feedback bit folds into the tap positions
    always_comb begin
        if (state_q[0]) begin
            state_d = {1'b0, state_q[15:1]} ^ TAPS;
        end else begin
            state_d = {1'b0, state_q[15:1]};
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
endmodule

// File: rtl/blackjack_deck.sv
// 52-card deck with Fisher-Yates shuffle (LFSR rejection sampling) that serves
// one card per request, one cycle after the request.
module blackjack_deck
    import blackjack_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [15:0] LFSR_TAPS = 16'hB400
) (
    input  logic              clk,
    input  logic              reset,
    blackjack_deck_if.slave   bus
);
    deck_state_e state_q, state_d;
    card_idx_t   deck_q [DECK_SIZE];
    card_idx_t   deck_d [DECK_SIZE];
    card_idx_t   i_q, i_d, j_q, j_d, ptr_q, ptr_d, cards_left_q, cards_left_d;
    card_t       card_q, card_d;
    logic        card_valid_q, card_valid_d, card_err_q, card_err_d;
    logic        shuffle_ok_q, shuffle_ok_d, deck_empty_q, deck_empty_d;
    logic [15:0] lfsr_s;
    card_idx_t   j_s;
    logic        deal_s;
    logic        unused_lfsr_s;

    bj_lfsr16 #(.SEED(LFSR_SEED), .TAPS(LFSR_TAPS)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .state (lfsr_s)
    );

    assign unused_lfsr_s = ^lfsr_s[15:6];
    assign j_s    = lfsr_s[5:0] & draw_mask(i_q);
    assign deal_s = (state_q == READY) && bus.card_req && !bus.shuffle_req && (ptr_q < 6'd52);

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            for (int k = 0; k < DECK_SIZE; k++) deck_q[k] <= card_idx_t'(k);
            i_q          <= 6'd0;
            j_q          <= 6'd0;
            ptr_q        <= 6'd0;
            card_q       <= '{rank: 4'd0, suit: 2'd0};
            card_valid_q <= 1'b0;
            card_err_q   <= 1'b0;
            shuffle_ok_q <= 1'b0;
            deck_empty_q <= 1'b0;
            cards_left_q <= 6'd0;
        end else begin
            state_q      <= state_d;
            deck_q       <= deck_d;
            i_q          <= i_d;
            j_q          <= j_d;
            ptr_q        <= ptr_d;
            card_q       <= card_d;
            card_valid_q <= card_valid_d;
            card_err_q   <= card_err_d;
            shuffle_ok_q <= shuffle_ok_d;
            deck_empty_q <= deck_empty_d;
            cards_left_q <= cards_left_d;
        end
    end

    // Next-state logic; a shuffle request overrides everything
    always_comb begin
        state_d = state_q;
        if (bus.shuffle_req) begin
            state_d = INIT;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                INIT:    state_d = DRAW;
                DRAW:    state_d = (j_s <= i_q) ? SWAP : DRAW;
                SWAP:    state_d = (i_q == 6'd1) ? READY : DRAW;
                READY:   state_d = READY;
                default: state_d = IDLE;
            endcase
        end
    end

    // Shuffle/deal datapath: identity load, draw index, swap, deal pointer
    always_comb begin
        deck_d = deck_q;
        i_d    = i_q;
        j_d    = j_q;
        ptr_d  = ptr_q;
        if (bus.shuffle_req) begin
            ptr_d = 6'd0;
        end else begin
            case (state_q)
                INIT: begin
                    for (int k = 0; k < DECK_SIZE; k++) deck_d[k] = card_idx_t'(k);
                    i_d   = 6'd51;
                    ptr_d = 6'd0;
                end
                DRAW: j_d = j_s;
                SWAP: begin
                    deck_d[i_q] = deck_q[j_q];
                    deck_d[j_q] = deck_q[i_q];
                    if (i_q == 6'd1) begin
                        ptr_d = 6'd0;
                    end else begin
                        i_d = i_q - 6'd1;
                    end
                end
                READY: begin
                    if (deal_s) begin
                        ptr_d = ptr_q + 6'd1;
                    end else begin
                        ptr_d = ptr_q;
                    end
                end
                default: ptr_d = ptr_q;
            endcase
        end
    end

    // Output decode, registered so every output comes straight from a flop
    always_comb begin
        card_valid_d = deal_s;
        card_err_d   = bus.card_req && !bus.shuffle_req && !deal_s;
        if (deal_s) begin
            card_d = idx_to_card(deck_q[ptr_q]);
        end else begin
            card_d = card_q;
        end
        shuffle_ok_d = (state_d == READY);
        deck_empty_d = (state_d == READY) && (ptr_d == 6'd52);
        cards_left_d = (state_d == READY) ? (6'd52 - ptr_d) : 6'd0;
    end

    assign bus.shuffle_ok = shuffle_ok_q;
    assign bus.card_valid = card_valid_q;
    assign bus.card_rank  = card_q.rank;
    assign bus.card_suit  = card_q.suit;
    assign bus.cards_left = cards_left_q;
    assign bus.deck_empty = deck_empty_q;
    assign bus.card_err   = card_err_q;
endmodule

// File: tb/tb_blackjack_deck.sv
// Directed self-checking bench for blackjack_deck.
module tb_blackjack_deck;
    import blackjack_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   seq_cur [52];
    int   seq_a   [52];
    int   seq_b   [52];
    int   n_wait;
    int   n_diff;
    logic [3:0] last_rank;
    logic [1:0] last_suit;

    blackjack_deck_if bus ();

    blackjack_deck dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.shuffle_req = 1'b0;
        bus.card_req = 1'b0;
        repeat (3) step();
        check("reset_ok", bus.shuffle_ok, 0);
        check("reset_left", bus.cards_left, 0);
        reset = 1'b1;
    endtask

    task automatic start_shuffle();
        bus.shuffle_req = 1'b1;
        step();
        bus.shuffle_req = 1'b0;
        check("shuf_ok_low", bus.shuffle_ok, 0);
        check("shuf_left_zero", bus.cards_left, 0);
        check("shuf_empty_low", bus.deck_empty, 0);
    endtask

    task automatic wait_ready();
        n_wait = 0;
        while (bus.shuffle_ok !== 1'b1 && n_wait < 2000) begin
            step();
            n_wait++;
        end
        check("ready_timeout", bus.shuffle_ok, 1);
        check("ready_left52", bus.cards_left, 52);
        check("ready_empty0", bus.deck_empty, 0);
    endtask

    task automatic deal(input int count, input int spacing);
        for (int k = 0; k < count; k++) begin
            bus.card_req = 1'b1;
            step();
            check("deal_valid", bus.card_valid, 1);
            check("deal_err", bus.card_err, 0);
            check("deal_left", bus.cards_left, 52 - (k + 1));
            check("deal_rank_range", 32'((bus.card_rank >= 4'd1) && (bus.card_rank <= 4'd13)), 1);
            seq_cur[k] = int'(bus.card_suit) * 13 + int'(bus.card_rank) - 1;
            if (spacing > 1) begin
                bus.card_req = 1'b0;
                step();
                check("deal_pulse", bus.card_valid, 0);
                repeat (spacing - 2) step();
            end
        end
        bus.card_req = 1'b0;
    endtask

    task automatic check_distinct();
        bit seen [52];
        int dups = 0;
        int moved = 0;
        for (int k = 0; k < 52; k++) seen[k] = 1'b0;
        for (int k = 0; k < 52; k++) begin
            if (seq_cur[k] < 0 || seq_cur[k] > 51 || seen[seq_cur[k]]) dups++;
            else seen[seq_cur[k]] = 1'b1;
            if (seq_cur[k] != k) moved++;
        end
        check("distinct_dups", dups, 0);
        check("shuffled_not_identity", 32'(moved > 0), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Run A: refusal before shuffle, spaced deal, exhaustion
        do_reset();
        repeat (4) step();
        bus.card_req = 1'b1;
        step();
        bus.card_req = 1'b0;
        check("idle_err", bus.card_err, 1);
        check("idle_valid", bus.card_valid, 0);
        check("idle_ok", bus.shuffle_ok, 0);
        check("idle_left", bus.cards_left, 0);
        check("idle_rank", bus.card_rank, 0);
        step();
        check("idle_err_pulse", bus.card_err, 0);
        start_shuffle();
        wait_ready();
        check("shuffle_min_len", 32'(n_wait >= 102), 1);
        deal(52, 3);
        check_distinct();
        check("empty_set", bus.deck_empty, 1);
        check("empty_left", bus.cards_left, 0);
        check("empty_ok", bus.shuffle_ok, 1);
        seq_a = seq_cur;
        last_rank = bus.card_rank;
        last_suit = bus.card_suit;
        bus.card_req = 1'b1;
        step();
        bus.card_req = 1'b0;
        check("extra_err", bus.card_err, 1);
        check("extra_valid", bus.card_valid, 0);
        check("extra_rank_hold", bus.card_rank, last_rank);
        check("extra_suit_hold", bus.card_suit, last_suit);

        // Run B: same request cycle, back-to-back deal
        do_reset();
        repeat (6) step();
        start_shuffle();
        wait_ready();
        deal(52, 1);
        n_diff = 0;
        for (int k = 0; k < 52; k++) if (seq_cur[k] != seq_a[k]) n_diff++;
        check("same_cycle_same_seq", n_diff, 0);
        seq_b = seq_cur;

        // Run C: request one cycle later
        do_reset();
        repeat (7) step();
        start_shuffle();
        wait_ready();
        deal(52, 1);
        check_distinct();
        n_diff = 0;
        for (int k = 0; k < 52; k++) if (seq_cur[k] != seq_b[k]) n_diff++;
        check("other_cycle_diff_seq", 32'(n_diff > 0), 1);

        // Restart mid-shuffle at i=30
        start_shuffle();
        n_wait = 0;
        while (!(dut.state_q == DRAW && dut.i_q == 6'd30) && n_wait < 2000) begin
            step();
            n_wait++;
        end
        check("reach_draw30", 32'(dut.state_q == DRAW && dut.i_q == 6'd30), 1);
        bus.shuffle_req = 1'b1;
        step();
        bus.shuffle_req = 1'b0;
        check("restart_state_init", 32'(dut.state_q == INIT), 1);
        check("restart_ok", bus.shuffle_ok, 0);
        wait_ready();
        deal(20, 2);

        // Restart mid-deal with a simultaneous card request
        bus.shuffle_req = 1'b1;
        bus.card_req = 1'b1;
        step();
        bus.shuffle_req = 1'b0;
        bus.card_req = 1'b0;
        check("middeal_ok", bus.shuffle_ok, 0);
        check("middeal_left", bus.cards_left, 0);
        check("middeal_valid", bus.card_valid, 0);
        check("middeal_err", bus.card_err, 0);
        check("middeal_empty", bus.deck_empty, 0);
        wait_ready();
        deal(52, 1);
        check_distinct();

        // Async reset in the middle of a SWAP cycle
        check("rank_nonzero_before", 32'(bus.card_rank != 4'd0), 1);
        start_shuffle();
        n_wait = 0;
        while (dut.state_q != SWAP && n_wait < 200) begin
            step();
            n_wait++;
        end
        check("reach_swap", 32'(dut.state_q == SWAP), 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_ok", bus.shuffle_ok, 0);
        check("arst_valid", bus.card_valid, 0);
        check("arst_err", bus.card_err, 0);
        check("arst_rank", bus.card_rank, 0);
        check("arst_suit", bus.card_suit, 0);
        check("arst_left", bus.cards_left, 0);
        check("arst_empty", bus.deck_empty, 0);
        n_diff = 0;
        for (int k = 0; k < 52; k++) if (int'(dut.deck_q[k]) != k) n_diff++;
        check("arst_deck_identity", n_diff, 0);
        repeat (2) step();
        reset = 1'b1;
        step();
        bus.card_req = 1'b1;
        step();
        bus.card_req = 1'b0;
        check("post_arst_err", bus.card_err, 1);
        check("post_arst_valid", bus.card_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
